// File: rtl/key_conditioner.sv
// key_conditioner: per-key 2-FF sync, debounce, press/release pulses.
// Define KEY_LONGPRESS_EN to build the long-press / auto-repeat pulse.
module key_conditioner #(
    parameter int NKEYS           = 4,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 5_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] key_raw,
    output logic [NKEYS-1:0] key_level,
    output logic [NKEYS-1:0] press_pulse,
    output logic [NKEYS-1:0] release_pulse,
    output logic [NKEYS-1:0] key_long
);

    localparam int MDH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ?
                         DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MX  = (MDH > REPEAT_CYCLES) ? MDH : REPEAT_CYCLES;
    localparam int CW  = $clog2(MX + 1);

    localparam logic [CW-1:0] DM1 = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [NKEYS-1:0] pol;
    logic [NKEYS-1:0] sync1_q;
    logic [NKEYS-1:0] sync2_q;

    assign pol = ACTIVE_LOW ? ~key_raw : key_raw;

    // Two-flop synchroniser on the pressed-polarity key level
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pol;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < NKEYS; g++) begin : g_key
        state_t        state_q;
        logic [CW-1:0] cnt_q;
        logic          level_q;
        logic          press_q;
        logic          rel_q;
        logic          s;

        assign s = sync2_q[g];

        // Debounce FSM: a change is accepted after D+1 agreeing samples
        always_ff @(posedge clk) begin
            if (!reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                unique case (state_q)
                    IDLE: begin
                        if (s) begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!s) begin
                            state_q <= IDLE;
                        end else if (cnt_q == DM1) begin
                            state_q <= PRESSED;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!s) begin
                            state_q <= RELEASE_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (s) begin
                            state_q <= PRESSED;
                        end else if (cnt_q == DM1) begin
                            state_q <= IDLE;
                            level_q <= 1'b0;
                            rel_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end

        assign key_level[g]     = level_q;
        assign press_pulse[g]   = press_q;
        assign release_pulse[g] = rel_q;

`ifdef KEY_LONGPRESS_EN
        localparam logic [CW-1:0] HM1 = CW'(HOLD_CYCLES - 1);
        localparam logic [CW-1:0] RM1 = CW'(REPEAT_CYCLES - 1);

        logic [CW-1:0] hold_q;
        logic          rep_q;
        logic          long_q;

        // Hold timer: first pulse after H, then every R; frozen while releasing
        always_ff @(posedge clk) begin
            if (!reset) begin
                hold_q <= '0;
                rep_q  <= 1'b0;
                long_q <= 1'b0;
            end else begin
                long_q <= 1'b0;
                unique case (state_q)
                    PRESSED: begin
                        if ((!rep_q && hold_q == HM1) ||
                            (rep_q && hold_q == RM1)) begin
                            long_q <= 1'b1;
                            hold_q <= '0;
                            rep_q  <= 1'b1;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                    RELEASE_WAIT: begin
                        hold_q <= hold_q;
                    end
                    default: begin
                        hold_q <= '0;
                        rep_q  <= 1'b0;
                    end
                endcase
            end
        end

        assign key_long[g] = long_q;
`else
        assign key_long[g] = 1'b0;
`endif
    end

endmodule
